// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: drives a req/gnt/rvalid data bus, aligns store data, extracts load lanes.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of issuing them.
module load_store_unit #(
  parameter logic [31:0] IDLE_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic [2:0]  mem_op_mem,
  input  logic        mem_write_mem,
  input  logic        mem_to_reg_mem,
  input  logic        pipe_adv,
  output logic [31:0] mem_rdata_mem,
  output logic        lsu_stall,
  output logic        lsu_misaligned,
  output logic        lsu_bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  state_t      state_q;
  logic [31:0] rdata_q;
  logic        berr_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic        bus_we_q;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;

  logic        in_idle;
  logic        access;
  logic        misaligned;
  logic        issue;
  logic        trap;
  logic [31:0] addr_fmt;
  logic [31:0] wdata_fmt;
  logic [3:0]  be_fmt;

  function automatic logic [3:0] byte_enables(input logic [2:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
    case (op[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Byte lane uses both address bits; the half lane only looks at addr[1].
  function automatic logic [31:0] load_data(input logic [2:0] op, input logic [1:0] lane,
                                            input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bx;
    logic signed [31:0] hx;
    b  = rd[{lane, 3'b000} +: 8];
    h  = lane[1] ? rd[31:16] : rd[15:0];
    bx = b;
    hx = h;
    case (op[1:0])
      2'b00:   return op[2] ? {24'h0, b} : bx;
      2'b01:   return op[2] ? {16'h0, h} : hx;
      default: return rd;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal_q;
  assign misaligned = ((mem_op_mem[1:0] == 2'b01) && mem_addr_mem[0]) ||
                      (mem_op_mem[1] && (mem_addr_mem[1:0] != 2'b00));
  assign lsu_misaligned = misal_q;
`else
  assign misaligned     = 1'b0;
  assign lsu_misaligned = 1'b0;
`endif

  assign in_idle   = (state_q == S_IDLE);
  assign access    = mem_write_mem | mem_to_reg_mem;
  assign issue     = in_idle && access && !misaligned && !reset;
  assign trap      = in_idle && access && misaligned && !reset;
  assign addr_fmt  = {mem_addr_mem[31:2], 2'b00};
  assign wdata_fmt = store_data(mem_op_mem, mem_wdata_mem);
  assign be_fmt    = byte_enables(mem_op_mem, mem_addr_mem[1:0]);

  // Issue cycle drives the live MEM fields; afterwards the latched copy keeps the bus stable.
  assign bus_req       = issue || (state_q == S_REQ);
  assign bus_we        = in_idle ? mem_write_mem : bus_we_q;
  assign bus_addr      = in_idle ? addr_fmt      : bus_addr_q;
  assign bus_wdata     = in_idle ? wdata_fmt     : bus_wdata_q;
  assign bus_be        = in_idle ? be_fmt        : bus_be_q;
  assign lsu_stall     = issue || (state_q == S_REQ) || (state_q == S_RSP);
  assign mem_rdata_mem = rdata_q;
  assign lsu_bus_err   = berr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= IDLE_RDATA;
      berr_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misal_q <= 1'b0;
`endif
    end else begin
      berr_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misal_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            state_q <= bus_gnt ? S_RSP : S_REQ;
          end else if (trap) begin
            state_q <= S_DONE;
`ifdef LSU_MISALIGN_TRAP_EN
            misal_q <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (bus_gnt) state_q <= S_RSP;
        end
        S_RSP: begin
          if (bus_rvalid) begin
            state_q <= S_DONE;
            berr_q  <= bus_err;
            if (!bus_we_q) rdata_q <= bus_err ? 32'h0 : load_data(op_q, lane_q, bus_rdata);
          end
        end
        S_DONE: begin
          if (pipe_adv) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      bus_addr_q  <= addr_fmt;
      bus_wdata_q <= wdata_fmt;
      bus_be_q    <= be_fmt;
      bus_we_q    <= mem_write_mem;
      op_q        <= mem_op_mem;
      lane_q      <= mem_addr_mem[1:0];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit with a bus responder and an arithmetic reference model.
module tb_load_store_unit;

  localparam logic [31:0] IDLE_RD = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr_mem, mem_wdata_mem, mem_rdata_mem;
  logic [2:0]  mem_op_mem;
  logic        mem_write_mem, mem_to_reg_mem, pipe_adv;
  logic        lsu_stall, lsu_misaligned, lsu_bus_err;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int vectors = 0;
  int miscompares = 0;

  int          o_stall, o_req;
  logic        o_stable, o_timeout, o_mis, o_err, o_mis_after, o_err_after, o_hold_bad, o_we;
  logic [31:0] o_addr, o_wdata, o_rdata, o_hold_rdata;
  logic [3:0]  o_be;

  always #5 clk = ~clk;

  load_store_unit #(.IDLE_RDATA(IDLE_RD)) dut (
    .clk(clk), .reset(reset),
    .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem), .mem_op_mem(mem_op_mem),
    .mem_write_mem(mem_write_mem), .mem_to_reg_mem(mem_to_reg_mem), .pipe_adv(pipe_adv),
    .mem_rdata_mem(mem_rdata_mem), .lsu_stall(lsu_stall), .lsu_misaligned(lsu_misaligned),
    .lsu_bus_err(lsu_bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int m_base(input int size, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    return a - (a % size);
  endfunction

  function automatic logic [3:0] m_be(input int size, input int base);
    int m;
    m = ((1 << size) - 1) << base;
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int size, input logic [31:0] wd);
    longint low, r;
    low = longint'(wd) & ((longint'(1) << (8 * size)) - 1);
    r = 0;
    for (int i = 0; i < 4 / size; i++) r = r | (low << (8 * size * i));
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input int size, input int base,
                                         input logic [31:0] rd);
    longint v;
    v = (longint'(rd) >> (8 * base)) & ((longint'(1) << (8 * size)) - 1);
    if ((op == 3'd0 || op == 3'd1) && v[8 * size - 1]) v = v - (longint'(1) << (8 * size));
    return v[31:0];
  endfunction

  function automatic logic m_misal(input int size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (size > 1) && ((addr % size) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver + bus responder (records observations only) ----------------
  task automatic run_access(input logic we, input logic ld, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int gd, input int rd, input logic [31:0] rdat,
                            input logic er, input logic noise, input int hold);
    int  k, gc;
    logic done;
    mem_write_mem = we; mem_to_reg_mem = ld; mem_op_mem = op;
    mem_addr_mem = addr; mem_wdata_mem = wd; pipe_adv = 1'b0;
    o_stall = 0; o_req = 0; o_stable = 1'b1; o_timeout = 1'b0; o_hold_bad = 1'b0;
    o_be = 4'h0; o_addr = 32'h0; o_wdata = 32'h0; o_we = 1'b0;
    gc = -1; done = 1'b0; k = 0;
    while (!done) begin
      #1;
      if (k >= 1 && !lsu_stall) begin
        done = 1'b1;
        o_mis = lsu_misaligned; o_err = lsu_bus_err; o_rdata = mem_rdata_mem;
        pipe_adv = (hold == 0);
        bus_gnt = 1'b0; bus_rvalid = noise & $urandom_range(0, 1); bus_err = 1'b0;
        bus_rdata = $urandom;
      end else begin
        if (lsu_stall) o_stall++;
        if (bus_req) begin
          if (o_req == 0) begin
            o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
          end else if (bus_be !== o_be || bus_addr !== o_addr || bus_wdata !== o_wdata ||
                       bus_we !== o_we) begin
            o_stable = 1'b0;
          end
          bus_gnt = (o_req == gd);
          if (o_req == gd) gc = k;
          o_req++;
        end else begin
          bus_gnt = 1'b0;
        end
        bus_rvalid = (gc >= 0) ? (k == gc + rd) : (noise & $urandom_range(0, 1));
        bus_err    = bus_rvalid & ((gc >= 0) ? er : 1'($urandom_range(0, 1)));
        bus_rdata  = (gc >= 0 && k == gc + rd) ? rdat : $urandom;
        if (k > 60) begin o_timeout = 1'b1; done = 1'b1; end
      end
      @(negedge clk);
      k++;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    for (int h = 0; h < hold; h++) begin
      #1;
      if (bus_req || lsu_stall) o_hold_bad = 1'b1;
      o_hold_rdata = mem_rdata_mem;
      pipe_adv = (h == hold - 1);
      @(negedge clk);
    end
    mem_write_mem = 1'b0; mem_to_reg_mem = 1'b0; pipe_adv = 1'b0;
    #1;
    o_mis_after = lsu_misaligned; o_err_after = lsu_bus_err;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1; mem_write_mem = 1'b0; mem_to_reg_mem = 1'b1; mem_op_mem = 3'b010;
    mem_addr_mem = 32'h40; mem_wdata_mem = 32'h0; pipe_adv = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", bus_req); end
    vectors++; if (lsu_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %b want 0", lsu_stall); end
    vectors++; if (lsu_misaligned !== 1'b0) begin miscompares++; $display("FAIL rst_mis got %b want 0", lsu_misaligned); end
    vectors++; if (lsu_bus_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", lsu_bus_err); end
    vectors++; if (mem_rdata_mem !== IDLE_RD) begin miscompares++; $display("FAIL rst_rdata got %h want %h", mem_rdata_mem, IDLE_RD); end
    mem_to_reg_mem = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw;
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 1'b0, 1'b0, 0);
    vectors++; if (o_timeout) begin miscompares++; $display("FAIL lw_timeout got 1 want 0"); end
    vectors++; if (o_be !== 4'b1111) begin miscompares++; $display("FAIL lw_be got %b want 1111", o_be); end
    vectors++; if (o_addr !== 32'h100) begin miscompares++; $display("FAIL lw_addr got %h want 100", o_addr); end
    vectors++; if (o_stall != 2) begin miscompares++; $display("FAIL lw_stall got %0d want 2", o_stall); end
    vectors++; if (o_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_rdata got %h want deadbeef", o_rdata); end
  endtask

  task automatic test_lb;
    run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 1, 2, 32'h80AABBCC, 1'b0, 1'b1, 0);
    vectors++; if (o_be !== 4'b1000) begin miscompares++; $display("FAIL lb_be got %b want 1000", o_be); end
    vectors++; if (o_rdata !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_rdata got %h want ffffff80", o_rdata); end
    run_access(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80AABBCC, 1'b0, 1'b0, 0);
    vectors++; if (o_rdata !== 32'h00000080) begin miscompares++; $display("FAIL lbu_rdata got %h want 00000080", o_rdata); end
  endtask

  task automatic test_sh_delayed;
    run_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 3, 1, 32'h13572468, 1'b0, 1'b1, 0);
    vectors++; if (o_req != 4) begin miscompares++; $display("FAIL sh_req_cycles got %0d want 4", o_req); end
    vectors++; if (o_stable !== 1'b1) begin miscompares++; $display("FAIL sh_stable got %b want 1", o_stable); end
    vectors++; if (o_be !== 4'b1100) begin miscompares++; $display("FAIL sh_be got %b want 1100", o_be); end
    vectors++; if (o_wdata !== 32'hABCDABCD) begin miscompares++; $display("FAIL sh_wdata got %h want abcdabcd", o_wdata); end
    vectors++; if (o_we !== 1'b1) begin miscompares++; $display("FAIL sh_we got %b want 1", o_we); end
    vectors++; if (o_stall != 5) begin miscompares++; $display("FAIL sh_stall got %0d want 5", o_stall); end
    vectors++; if (o_rdata !== 32'h00000080) begin miscompares++; $display("FAIL sh_rdata_kept got %h want 00000080", o_rdata); end
  endtask

  task automatic test_misaligned;
    run_access(1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 0, 1, 32'hF00D8001, 1'b0, 1'b0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    vectors++; if (o_req != 0) begin miscompares++; $display("FAIL mis_req got %0d want 0", o_req); end
    vectors++; if (o_stall != 0) begin miscompares++; $display("FAIL mis_stall got %0d want 0", o_stall); end
    vectors++; if (o_mis !== 1'b1) begin miscompares++; $display("FAIL mis_pulse got %b want 1", o_mis); end
    vectors++; if (o_mis_after !== 1'b0) begin miscompares++; $display("FAIL mis_pulse_len got %b want 0", o_mis_after); end
    vectors++; if (o_rdata !== 32'h00000080) begin miscompares++; $display("FAIL mis_rdata got %h want 00000080", o_rdata); end
`else
    vectors++; if (o_be !== 4'b0011) begin miscompares++; $display("FAIL lh101_be got %b want 0011", o_be); end
    vectors++; if (o_mis !== 1'b0) begin miscompares++; $display("FAIL lh101_mis got %b want 0", o_mis); end
    vectors++; if (o_rdata !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh101_rdata got %h want ffff8001", o_rdata); end
`endif
  endtask

  task automatic test_bus_err;
    run_access(1'b0, 1'b1, 3'b010, 32'h110, 32'h0, 1, 1, 32'hCAFEF00D, 1'b1, 1'b0, 0);
    vectors++; if (o_rdata !== 32'h0) begin miscompares++; $display("FAIL err_rdata got %h want 0", o_rdata); end
    vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL err_pulse got %b want 1", o_err); end
    vectors++; if (o_err_after !== 1'b0) begin miscompares++; $display("FAIL err_pulse_len got %b want 0", o_err_after); end
  endtask

  task automatic test_done_hold;
    run_access(1'b0, 1'b1, 3'b101, 32'h122, 32'h0, 0, 2, 32'h9ABC1234, 1'b0, 1'b1, 3);
    vectors++; if (o_hold_bad !== 1'b0) begin miscompares++; $display("FAIL hold_reissue got %b want 0", o_hold_bad); end
    vectors++; if (o_hold_rdata !== 32'h00009ABC) begin miscompares++; $display("FAIL hold_rdata got %h want 00009abc", o_hold_rdata); end
  endtask

  task automatic test_reset_abandon;
    mem_write_mem = 1'b0; mem_to_reg_mem = 1'b1; mem_op_mem = 3'b010; mem_addr_mem = 32'h300;
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    vectors++; if (lsu_stall !== 1'b1) begin miscompares++; $display("FAIL abandon_rsp_stall got %b want 1", lsu_stall); end
    reset = 1'b1;
    #1;
    vectors++; if (lsu_stall !== 1'b0) begin miscompares++; $display("FAIL abandon_stall got %b want 0", lsu_stall); end
    vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL abandon_req got %b want 0", bus_req); end
    mem_to_reg_mem = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    vectors++; if (mem_rdata_mem !== IDLE_RD) begin miscompares++; $display("FAIL abandon_rdata got %h want %h", mem_rdata_mem, IDLE_RD); end
    vectors++; if (lsu_stall !== 1'b0) begin miscompares++; $display("FAIL abandon_idle got %b want 0", lsu_stall); end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] model_rd, addr, wd, rdat;
    logic [2:0]  op;
    logic        we, ld, er, mis;
    int          gd, rd, size, base;
    model_rd = IDLE_RD;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7)); addr = $urandom; wd = $urandom; rdat = $urandom;
      we = 1'($urandom_range(0, 1)); ld = !we || 1'($urandom_range(0, 1));
      gd = $urandom_range(0, 3); rd = $urandom_range(1, 3); er = ($urandom_range(0, 7) == 0);
      size = m_size(op); base = m_base(size, addr); mis = m_misal(size, addr);
      run_access(we, ld, op, addr, wd, gd, rd, rdat, er, 1'b1, 0);
      vectors++; if (o_timeout) begin miscompares++; $display("FAIL rnd%0d_timeout got 1 want 0", n); end
      if (mis) begin
        vectors++; if (o_req != 0 || o_stall != 0 || o_mis !== 1'b1) begin
          miscompares++; $display("FAIL rnd%0d_trap got req=%0d stall=%0d mis=%b want 0 0 1", n, o_req, o_stall, o_mis);
        end
      end else begin
        if (!we) model_rd = er ? 32'h0 : m_load(op, size, base, rdat);
        vectors++; if (o_be !== m_be(size, base)) begin miscompares++; $display("FAIL rnd%0d_be got %b want %b", n, o_be, m_be(size, base)); end
        vectors++; if (o_addr !== {addr[31:2], 2'b00}) begin miscompares++; $display("FAIL rnd%0d_addr got %h want %h", n, o_addr, {addr[31:2], 2'b00}); end
        vectors++; if (o_we !== we) begin miscompares++; $display("FAIL rnd%0d_we got %b want %b", n, o_we, we); end
        if (we) begin
          vectors++; if (o_wdata !== m_wdata(size, wd)) begin miscompares++; $display("FAIL rnd%0d_wdata got %h want %h", n, o_wdata, m_wdata(size, wd)); end
        end
        vectors++; if (o_stall != gd + rd + 1) begin miscompares++; $display("FAIL rnd%0d_stall got %0d want %0d", n, o_stall, gd + rd + 1); end
        vectors++; if (o_req != gd + 1 || !o_stable) begin miscompares++; $display("FAIL rnd%0d_req got %0d stable=%b want %0d", n, o_req, o_stable, gd + 1); end
        vectors++; if (o_err !== er || o_err_after !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_err got %b/%b want %b/0", n, o_err, o_err_after, er); end
        vectors++; if (o_mis !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_mis got %b want 0", n, o_mis); end
      end
      vectors++; if (o_rdata !== model_rd) begin miscompares++; $display("FAIL rnd%0d_rdata got %h want %h", n, o_rdata, model_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sh_delayed();
    test_misaligned();
    test_bus_err();
    test_done_hold();
    test_reset_abandon();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
